// File: rtl/boot_memh_parser.sv
// Boot loader text parser: turns a readmemh-style character stream into
// addressed word write strobes; a load session ends after an idle timeout.
module boot_memh_parser #(
   parameter int address_width      = 32,
   parameter int data_width         = 32,
   parameter int char_width         = 8,
   parameter int clk_frequency      = 50000000,
   parameter int timeout_in_seconds = 1,
   parameter bit byte_swap          = 1'b0,
   parameter int count_width        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [char_width-1:0]    in_char,
   output logic                     out_valid,
   output logic [address_width-1:0] out_address,
   output logic [data_width-1:0]    out_data,
   output logic                     busy,
   output logic                     error,
   output logic [1:0]               error_code,
   output logic [count_width-1:0]   word_count
);
   localparam longint timeout_cycles = longint'(timeout_in_seconds) * longint'(clk_frequency);
   localparam int timer_width = $clog2(timeout_cycles + 1);
   localparam logic [timer_width-1:0] timer_load = timer_width'(timeout_cycles);
   localparam int data_nibbles = data_width / 4;
   localparam int addr_nibbles = address_width / 4;
   localparam int max_nibbles = (data_nibbles > addr_nibbles) ? data_nibbles : addr_nibbles;
   localparam int nib_width = $clog2(max_nibbles + 1);
   localparam int byte_shift = $clog2(data_width / 8);

   typedef enum logic [2:0] {IDLE, DATA, ADDR, SLASH, COMMENT, ERR} state_t;
   state_t state_reg, state_next;

   logic [timer_width-1:0]   timer_reg;
   logic [data_width-1:0]    acc_reg, acc_swapped, emit_data, out_data_reg;
   logic [address_width-1:0] addr_acc_reg, word_address_reg, out_address_reg;
   logic [nib_width-1:0]     nib_count_reg;
   logic [count_width-1:0]   word_count_reg;
   logic                     out_valid_reg, error_reg;
   logic [1:0]               error_code_reg, cause;
   logic                     timeout, data_full, addr_full;
   logic                     is_hex, is_space, is_at, is_slash, is_under, is_lf;
   logic [3:0]               nibble;
   logic                     data_load, data_shift, addr_start, addr_shift, addr_commit, emit;

   // Letters a-f / A-F carry their value minus 9 in the low nibble.
   always_comb begin
      is_hex = 1'b0;
      nibble = in_char[3:0];
      if (in_char >= char_width'(8'h30) && in_char <= char_width'(8'h39)) begin
         is_hex = 1'b1;
      end else if ((in_char >= char_width'(8'h41) && in_char <= char_width'(8'h46)) ||
                   (in_char >= char_width'(8'h61) && in_char <= char_width'(8'h66))) begin
         is_hex = 1'b1;
         nibble = in_char[3:0] + 4'd9;
      end
   end

   assign is_lf    = in_char == char_width'(8'h0A);
   assign is_space = is_lf || in_char == char_width'(8'h20) || in_char == char_width'(8'h09) ||
                     in_char == char_width'(8'h0D);
   assign is_at    = in_char == char_width'(8'h40);
   assign is_slash = in_char == char_width'(8'h2F);
   assign is_under = in_char == char_width'(8'h5F);

   assign timeout   = (timer_reg == timer_width'(1)) && !in_valid;
   assign data_full = nib_count_reg == nib_width'(data_nibbles);
   assign addr_full = nib_count_reg == nib_width'(addr_nibbles);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cause      = 2'd0;
      if (timeout) begin
         state_next = IDLE;
      end else if (in_valid) begin
         case (state_reg)
            IDLE: begin
               if (is_hex)                     state_next = DATA;
               else if (is_at)                 state_next = ADDR;
               else if (is_slash)              state_next = SLASH;
               else if (!(is_space || is_under)) cause = 2'd1;
            end
            DATA: begin
               if (is_hex)        begin if (data_full) cause = 2'd2; end
               else if (is_space) state_next = IDLE;
               else if (is_slash) state_next = SLASH;
               else if (is_at)    cause = 2'd3;
               else if (!is_under) cause = 2'd1;
            end
            ADDR: begin
               if (is_hex) begin
                  if (addr_full) cause = 2'd2;
               end else if (is_space || is_slash) begin
                  if (nib_count_reg == '0) cause = 2'd3;
                  else state_next = is_slash ? SLASH : IDLE;
               end else if (is_at) begin
                  cause = 2'd3;
               end else if (!is_under) begin
                  cause = 2'd1;
               end
            end
            SLASH: begin
               if (is_slash) state_next = COMMENT;
               else          cause = 2'd1;
            end
            COMMENT: if (is_lf) state_next = IDLE;
            default: ;
         endcase
         if (cause != 2'd0) state_next = ERR;
      end
   end

   // A timeout in DATA flushes the partial word before the session clears.
   always_comb begin
      data_load   = 1'b0;
      data_shift  = 1'b0;
      addr_start  = 1'b0;
      addr_shift  = 1'b0;
      addr_commit = 1'b0;
      emit        = 1'b0;
      if (timeout) begin
         emit = (state_reg == DATA) && (nib_count_reg != '0);
      end else if (in_valid) begin
         case (state_reg)
            IDLE: begin
               data_load  = is_hex;
               addr_start = is_at;
            end
            DATA: begin
               data_shift = is_hex && !data_full;
               emit       = is_space || is_slash;
            end
            ADDR: begin
               addr_shift  = is_hex && !addr_full;
               addr_commit = (is_space || is_slash) && (nib_count_reg != '0);
            end
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < data_width / 8; gi++) begin : g_swap
      assign acc_swapped[gi*8 +: 8] = acc_reg[data_width-8-gi*8 +: 8];
   end
   assign emit_data = byte_swap ? acc_swapped : acc_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_reg        <= '0;
         acc_reg          <= '0;
         addr_acc_reg     <= '0;
         nib_count_reg    <= '0;
         word_address_reg <= '0;
         word_count_reg   <= '0;
         out_valid_reg    <= 1'b0;
         out_data_reg     <= '0;
         out_address_reg  <= '0;
         error_reg        <= 1'b0;
         error_code_reg   <= 2'd0;
      end else begin
         if (in_valid)              timer_reg <= timer_load;
         else if (timer_reg != '0) timer_reg <= timer_reg - timer_width'(1);

         out_valid_reg <= emit;
         if (emit) begin
            out_data_reg    <= emit_data;
            out_address_reg <= word_address_reg << byte_shift;
         end

         // A flushed word stays counted for one cycle, then the idle session clears it.
         if (timeout && !emit)      word_count_reg <= '0;
         else if (emit) begin
            if (word_count_reg != '1) word_count_reg <= word_count_reg + count_width'(1);
         end
         else if (timer_reg == '0) word_count_reg <= '0;

         if (timeout) begin
            acc_reg          <= '0;
            addr_acc_reg     <= '0;
            nib_count_reg    <= '0;
            word_address_reg <= '0;
            error_reg        <= 1'b0;
            error_code_reg   <= 2'd0;
         end else begin
            if (data_load) begin
               acc_reg       <= data_width'(nibble);
               nib_count_reg <= nib_width'(1);
            end else if (data_shift) begin
               acc_reg       <= data_width'({acc_reg, nibble});
               nib_count_reg <= nib_count_reg + nib_width'(1);
            end else if (addr_start) begin
               addr_acc_reg  <= '0;
               nib_count_reg <= '0;
            end else if (addr_shift) begin
               addr_acc_reg  <= address_width'({addr_acc_reg, nibble});
               nib_count_reg <= nib_count_reg + nib_width'(1);
            end
            if (addr_commit) word_address_reg <= addr_acc_reg;
            else if (emit)   word_address_reg <= word_address_reg + address_width'(1);
            if (cause != 2'd0) begin
               error_reg      <= 1'b1;
               error_code_reg <= cause;
            end
         end
      end
   end

   assign out_valid   = out_valid_reg;
   assign out_address = out_address_reg;
   assign out_data    = out_data_reg;
   assign busy        = timer_reg != '0;
   assign error       = error_reg;
   assign error_code  = error_code_reg;
   assign word_count  = word_count_reg;
endmodule

// File: tb/tb_boot_memh_parser.sv
// Bench for boot_memh_parser: table of text sessions plus random sessions,
// each checked against a token-level reference parser of the character stream.
module tb_boot_memh_parser;
   localparam int T = 20;

   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
   logic [7:0]  in_char = 8'h00;
   logic        out_valid, busy, error, sw_valid, sw_busy, sw_error;
   logic [31:0] out_address, out_data, sw_address, sw_data;
   logic [1:0]  error_code, sw_code;
   logic [15:0] word_count, sw_count;

   boot_memh_parser #(.clk_frequency(T), .timeout_in_seconds(1), .byte_swap(1'b0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
      .out_valid(out_valid), .out_address(out_address), .out_data(out_data),
      .busy(busy), .error(error), .error_code(error_code), .word_count(word_count));

   boot_memh_parser #(.clk_frequency(T), .timeout_in_seconds(1), .byte_swap(1'b1)) dut_sw (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
      .out_valid(sw_valid), .out_address(sw_address), .out_data(sw_data),
      .busy(sw_busy), .error(sw_error), .error_code(sw_code), .word_count(sw_count));

   always #5 clk = ~clk;

   int total = 0, bad = 0, seen_code = 0, exp_code = 0;
   logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$], got_sw[$];
   bit          exp_flush[$], got_busy[$];
   int          got_wc[$];

   typedef struct {
      string       text;
      int          gap_at;
      int          n;
      logic [31:0] a0, d0, al, dl;
      int          code;
   } vec_t;
   vec_t vecs[$];

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         got_a.push_back(out_address);
         got_d.push_back(out_data);
         got_busy.push_back(busy);
         got_wc.push_back(int'(word_count));
      end
      if (!reset && sw_valid) got_sw.push_back(sw_data);
   end

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   function automatic bit is_hex_c(logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
   endfunction

   function automatic logic [3:0] hex_val(logic [7:0] c);
      if (c <= 8'h39) return 4'(c - 8'h30);
      if (c <= 8'h46) return 4'(c - 8'h41 + 8'd10);
      return 4'(c - 8'h61 + 8'd10);
   endfunction

   function automatic bit is_ws(logic [7:0] c);
      return c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A;
   endfunction

   function automatic logic [31:0] bswap(logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   // Reference: walk the text token by token, as a readmemh reader would.
   task automatic model_session(input string s);
      int i, n, nd;
      bit is_addr;
      logic [31:0] wa, v;
      logic [7:0] c;
      exp_a.delete(); exp_d.delete(); exp_flush.delete();
      exp_code = 0; i = 0; n = s.len(); wa = 0;
      while (i < n && exp_code == 0) begin
         c = s[i];
         if (is_ws(c) || c == 8'h5F) begin
            i++;
         end else if (c == 8'h2F) begin
            if (i + 1 >= n) i = n;
            else if (s[i+1] != 8'h2F) exp_code = 1;
            else begin
               i += 2;
               while (i < n && s[i] != 8'h0A) i++;
            end
         end else if (c == 8'h40 || is_hex_c(c)) begin
            is_addr = (c == 8'h40);
            if (is_addr) i++;
            nd = 0; v = 0;
            while (i < n && exp_code == 0 && (is_hex_c(s[i]) || s[i] == 8'h5F)) begin
               if (s[i] != 8'h5F) begin
                  nd++;
                  if (nd > 8) exp_code = 2;
                  else v = {v[27:0], hex_val(s[i])};
               end
               i++;
            end
            if (exp_code == 0 && i >= n) begin
               if (!is_addr) begin
                  exp_a.push_back(wa << 2); exp_d.push_back(v); exp_flush.push_back(1'b1);
               end
            end else if (exp_code == 0) begin
               c = s[i];
               if (is_ws(c) || c == 8'h2F) begin
                  if (is_addr) begin
                     if (nd == 0) exp_code = 3;
                     else wa = v;
                  end else begin
                     exp_a.push_back(wa << 2); exp_d.push_back(v); exp_flush.push_back(1'b0);
                     wa = wa + 32'd1;
                  end
               end else if (c == 8'h40) exp_code = 3;
               else exp_code = 1;
            end
         end else begin
            exp_code = 1;
         end
      end
   endtask

   task automatic run_session(input string s, input int gap_at);
      int gap, m;
      model_session(s);
      got_a.delete(); got_d.delete(); got_sw.delete(); got_busy.delete(); got_wc.delete();
      for (int i = 0; i < s.len(); i++) begin
         gap = (i == gap_at) ? T - 1 : int'($urandom_range(0, 3));
         repeat (gap) begin @(posedge clk); #1; end
         in_char = s[i]; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0; in_char = 8'($urandom);
      end
      @(negedge clk);
      seen_code = int'(error_code);
      check("error_flag", error, exp_code != 0);
      check("error_code", error_code, exp_code);
      for (int k = 0; k < T + 4 && busy; k++) @(negedge clk);
      check("busy_falls", busy, 0);
      @(negedge clk);
      check("count_cleared", word_count, 0);
      check("error_cleared", {error, error_code}, 0);
      check("strobe_count", got_a.size(), exp_a.size());
      check("swap_strobe_count", got_sw.size(), exp_d.size());
      m = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
      for (int j = 0; j < m; j++) begin
         check("address", got_a[j], exp_a[j]);
         check("data", got_d[j], exp_d[j]);
         check("word_count", got_wc[j], j + 1);
         check("busy_at_strobe", got_busy[j], !exp_flush[j]);
         if (j < got_sw.size()) check("swapped_data", got_sw[j], bswap(exp_d[j]));
      end
      $display("session len=%0d strobes=%0d expected=%0d code=%0d", s.len(), got_a.size(), exp_a.size(), seen_code);
      @(posedge clk); #1;
   endtask

   task automatic add_vec(input string t, input int g, input int n, input logic [31:0] a0, d0, al, dl,
                          input int code);
      vec_t v;
      v.text = t; v.gap_at = g; v.n = n; v.a0 = a0; v.d0 = d0; v.al = al; v.dl = dl; v.code = code;
      vecs.push_back(v);
   endtask

   function automatic string rand_hex(int n);
      string digits = "0123456789abcdefABCDEF";
      string s = "";
      int j;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 7) == 0) s = {s, "_"};
         j = int'($urandom_range(0, 21));
         s = {s, digits.substr(j, j)};
      end
      return s;
   endfunction

   function automatic string rand_session();
      string s = "";
      string seps = " \n\t\r";
      int ntok = int'($urandom_range(1, 6));
      int j;
      for (int k = 0; k < ntok; k++) begin
         case ($urandom_range(0, 15))
            0, 1:    s = {s, "@", rand_hex(int'($urandom_range(1, 8)))};
            2:       s = {s, "// x@Gz/\n"};
            3:       s = {s, rand_hex(9)};
            4:       s = {s, "Q"};
            5:       s = {s, "@"};
            default: s = {s, rand_hex(int'($urandom_range(1, 8)))};
         endcase
         if (k < ntok - 1 || $urandom_range(0, 1) == 1) begin
            j = int'($urandom_range(0, 3));
            s = {s, seps.substr(j, j)};
         end
      end
      return s;
   endfunction

   initial begin
      add_vec("@10\n12345678 9abcdef0\n", -1, 2, 32'h40, 32'h12345678, 32'h44, 32'h9ABCDEF0, 0);
      add_vec("1f // note @zz\nDEAD_BEEF\n", -1, 2, 32'h0, 32'h1F, 32'h4, 32'hDEADBEEF, 0);
      add_vec("11223344 ", -1, 1, 32'h0, 32'h11223344, 32'h0, 32'h11223344, 0);
      add_vec("123456789 ", -1, 0, 0, 0, 0, 0, 2);
      add_vec("12G", -1, 0, 0, 0, 0, 0, 1);
      add_vec("@ 5", -1, 0, 0, 0, 0, 0, 3);
      add_vec("abcd", -1, 1, 32'h0, 32'hABCD, 32'h0, 32'hABCD, 0);
      add_vec("@10\nAA BB ", 7, 2, 32'h40, 32'hAA, 32'h44, 32'hBB, 0);
      add_vec("1 2 @3/x", -1, 2, 32'h0, 32'h1, 32'h4, 32'h2, 1);
      add_vec("12@", -1, 0, 0, 0, 0, 0, 3);
      add_vec("@123456789 ", -1, 0, 0, 0, 0, 0, 2);
      add_vec("ff/", -1, 1, 32'h0, 32'hFF, 32'h0, 32'hFF, 0);
      add_vec("@ffffffff 1 2 ", -1, 2, 32'hFFFFFFFC, 32'h1, 32'h0, 32'h2, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_address", out_address, 0);
      check("reset_out_data", out_data, 0);
      check("reset_busy", busy, 0);
      check("reset_error", {error, error_code}, 0);
      check("reset_word_count", word_count, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < vecs.size(); v++) begin
         run_session(vecs[v].text, vecs[v].gap_at);
         check("table_strobes", got_a.size(), vecs[v].n);
         check("table_code", seen_code, vecs[v].code);
         if (vecs[v].n > 0 && got_a.size() == vecs[v].n) begin
            check("table_first_address", got_a[0], vecs[v].a0);
            check("table_first_data", got_d[0], vecs[v].d0);
            check("table_last_address", got_a[vecs[v].n-1], vecs[v].al);
            check("table_last_data", got_d[vecs[v].n-1], vecs[v].dl);
         end
      end

      // Reset in the middle of a token must abort it without a strobe.
      got_a.delete();
      for (int i = 0; i < 3; i++) begin
         in_char = 8'h41 + 8'(i); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midtoken_reset_valid", out_valid, 0);
      check("midtoken_reset_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (T + 4) @(posedge clk);
      #1;
      check("midtoken_no_strobe", got_a.size(), 0);
      run_session("5 ", -1);
      check("after_reset_strobes", got_a.size(), 1);
      if (got_d.size() == 1) check("after_reset_data", got_d[0], 32'h5);

      for (int r = 0; r < 40; r++) run_session(rand_session(), -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
